pipe_link_channel: RTL and testbench
====================================

// Module: pipe_link_channel
// PURPOSE
//   Point-to-point PIPE channel joining two PCIE_TOP instances (side A = RC, side B = EP) at the pipe_tx*/pipe_rx* pins.
//   Models link bring-up (DOWN/TRAIN/ACTIVE) and a fixed per-direction wire latency, and counts delivered and dropped beats.
//   Sits directly downstream of each PCIE_TOP's PIPE transmitter and upstream of the peer's PIPE receiver.
// PARAMETERS
//   PIPE_DATA_WIDTH   256  beat width; matches the PCIE_TOP PIPE bus
//   LATENCY           4    cycles from input sample to output beat in each direction; legal range >=1
//   LINK_UP_DELAY     16   cycles spent in TRAIN before ACTIVE; legal range >=1
//   CNT_WIDTH         32   width of the statistics counters
// PORTS
//   clk            in   1                        single clock for all logic
//   rst_n          in   1                        asynchronous, active-low reset
//   link_en_i      in   1                        level; 1 requests link up, 0 forces DOWN
//   a_txdata_i     in   PIPE_DATA_WIDTH          side A transmit data
//   a_txvalid_i    in   1                        side A transmit valid
//   a_rxdata_o     out  PIPE_DATA_WIDTH          side A receive data (B->A)
//   a_rxvalid_o    out  1                        side A receive valid
//   b_txdata_i     in   PIPE_DATA_WIDTH          side B transmit data
//   b_txvalid_i    in   1                        side B transmit valid
//   b_rxdata_o     out  PIPE_DATA_WIDTH          side B receive data (A->B)
//   b_rxvalid_o    out  1                        side B receive valid
//   link_up_o      out  1                        1 while state==ACTIVE
//   a2b_cnt_o      out  CNT_WIDTH                count of beats delivered on b_rx*
//   b2a_cnt_o      out  CNT_WIDTH                count of beats delivered on a_rx*
//   drop_cnt_o     out  CNT_WIDTH                count of input beats discarded while not ACTIVE
//   err_inj_i      in   1                        one-cycle pulse that arms a single-bit error
//   err_dir_i      in   1                        0 = A->B, 1 = B->A
//   err_bit_i      in   $clog2(PIPE_DATA_WIDTH)  index of the bit to invert
//   err_pending_o  out  1                        an armed error is waiting for its beat
// BEHAVIOUR
//   Reset: every output is 0; FSM in DOWN; delay lines, counters and the armed error are cleared. Reset acts immediately, mid-operation included.
//   FSM states and transitions:
//     - DOWN -> TRAIN when link_en_i=1. The train counter is cleared on entry.
//     - TRAIN: the train counter increments every cycle. TRAIN -> ACTIVE on the cycle the counter equals LINK_UP_DELAY-1.
//     - From TRAIN or ACTIVE: link_en_i=0 -> DOWN on the next edge. link_en_i=0 has priority over the TRAIN->ACTIVE transition.
//     - link_up_o is registered and equals (state==ACTIVE).
//   Data path: each direction is a LATENCY-stage shift register carrying {valid, data}.
//     - A beat sampled with txvalid=1 in ACTIVE appears on the peer's rx* exactly LATENCY cycles later.
//     - Order is always preserved. There is no backpressure.
//     - rxdata_o is all-zero whenever rxvalid_o=0.
//   Not ACTIVE:
//     - An input beat with txvalid=1 enters the delay line as an invalid beat and increments drop_cnt_o.
//     - Both sides dropping in the same cycle adds 2.
//   Leaving ACTIVE: all valid bits in both delay lines are cleared on that same edge, so no beat emerges after link_up_o falls.
//   Counters:
//     - a2b_cnt_o / b2a_cnt_o increment on each cycle the matching rxvalid_o=1.
//     - All counters saturate at all-ones and are cleared only by reset.
// CONFIGURATION
//   Macro PIPE_LINK_ERR_INJ_EN. When defined:
//     - Arming: err_inj_i=1 while not pending latches err_dir_i and err_bit_i and sets err_pending_o on the next edge.
//     - A pulse while pending is ignored.
//     - Application: the first valid beat sampled in the armed direction in ACTIVE, from the cycle after arming onward, enters the delay line with bit err_bit_i inverted. err_pending_o clears on that edge.
//     - Leaving ACTIVE clears the pending error.
//   When not defined: err_* inputs are ignored, err_pending_o is tied to 0 and data passes unmodified.
// TESTING
//   T1 bring-up: release reset with link_en_i=1 -> link_up_o rises 1+LINK_UP_DELAY edges later (17 with defaults); all outputs are 0 before that.
//   T2 latency: in ACTIVE, drive A tx 0xA5 (valid) for one cycle -> b_rxvalid_o=1 with data 0xA5 exactly 4 cycles later; a2b_cnt_o=1.
//   T3 simultaneous: 8 back-to-back beats on both sides -> 8 in-order beats on each rx; a2b_cnt_o=b2a_cnt_o=8; drop_cnt_o=0.
//   T4 link drop: 3 beats in flight, then link_en_i=0 -> no rxvalid afterwards; later tx beats with valid set raise drop_cnt_o by 1 per beat per side.
//   T5 error (macro defined): arm dir=0, bit=5, then send 0x00 twice -> b_rx gets 0x20 then 0x00; err_pending_o falls on the first beat.
//   T6 async reset asserted mid-stream -> outputs 0 immediately; after re-release the FSM retrains from DOWN.

Source files
------------

// File: rtl/pipe_link_channel.sv
// PIPE channel between two PCIe tops: DOWN/TRAIN/ACTIVE bring-up, fixed per-direction delay lines, beat statistics.
// Optional single-bit error injection is compiled in with `define PIPE_LINK_ERR_INJ_EN.
module pipe_link_channel #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int LATENCY         = 4,
  parameter int LINK_UP_DELAY   = 16,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               link_en_i,
  input  logic [PIPE_DATA_WIDTH-1:0]         a_txdata_i,
  input  logic                               a_txvalid_i,
  output logic [PIPE_DATA_WIDTH-1:0]         a_rxdata_o,
  output logic                               a_rxvalid_o,
  input  logic [PIPE_DATA_WIDTH-1:0]         b_txdata_i,
  input  logic                               b_txvalid_i,
  output logic [PIPE_DATA_WIDTH-1:0]         b_rxdata_o,
  output logic                               b_rxvalid_o,
  output logic                               link_up_o,
  output logic [CNT_WIDTH-1:0]               a2b_cnt_o,
  output logic [CNT_WIDTH-1:0]               b2a_cnt_o,
  output logic [CNT_WIDTH-1:0]               drop_cnt_o,
  input  logic                               err_inj_i,
  input  logic                               err_dir_i,
  input  logic [$clog2(PIPE_DATA_WIDTH)-1:0] err_bit_i,
  output logic                               err_pending_o
);

  localparam int TW = $clog2(LINK_UP_DELAY + 1);
  localparam logic [TW-1:0] TRAIN_LAST = TW'(LINK_UP_DELAY - 1);
  localparam int BW = $clog2(PIPE_DATA_WIDTH);

  typedef enum logic [1:0] {DOWN, TRAIN, ACTIVE} state_t;

  state_t          state;
  logic [TW-1:0]   train_cnt;
  logic            is_active;
  logic            leaving;

  assign is_active = (state == ACTIVE);
  assign leaving   = is_active && !link_en_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DOWN;
      train_cnt <= '0;
      link_up_o <= 1'b0;
    end else begin
      case (state)
        DOWN: begin
          if (link_en_i) begin
            state     <= TRAIN;
            train_cnt <= '0;
          end
        end
        TRAIN: begin
          if (!link_en_i) begin
            state <= DOWN;
          end else if (train_cnt == TRAIN_LAST) begin
            state     <= ACTIVE;
            link_up_o <= 1'b1;
          end else begin
            train_cnt <= train_cnt + TW'(1);
          end
        end
        ACTIVE: begin
          if (!link_en_i) begin
            state     <= DOWN;
            link_up_o <= 1'b0;
          end
        end
        default: begin
          state     <= DOWN;
          link_up_o <= 1'b0;
        end
      endcase
    end
  end

  logic [PIPE_DATA_WIDTH-1:0] a_flip;
  logic [PIPE_DATA_WIDTH-1:0] b_flip;

`ifdef PIPE_LINK_ERR_INJ_EN
  logic          err_dir_q;
  logic [BW-1:0] err_bit_q;
  logic          hit_a;
  logic          hit_b;

  assign hit_a  = err_pending_o && !err_dir_q && is_active && a_txvalid_i;
  assign hit_b  = err_pending_o &&  err_dir_q && is_active && b_txvalid_i;
  assign a_flip = hit_a ? (PIPE_DATA_WIDTH'(1) << err_bit_q) : '0;
  assign b_flip = hit_b ? (PIPE_DATA_WIDTH'(1) << err_bit_q) : '0;

  // A pulse while already armed is ignored; leaving ACTIVE disarms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pending_o <= 1'b0;
      err_dir_q     <= 1'b0;
      err_bit_q     <= '0;
    end else if (leaving) begin
      err_pending_o <= 1'b0;
    end else if (hit_a || hit_b) begin
      err_pending_o <= 1'b0;
    end else if (!err_pending_o && err_inj_i) begin
      err_pending_o <= 1'b1;
      err_dir_q     <= err_dir_i;
      err_bit_q     <= err_bit_i;
    end
  end
`else
  logic unused_err;
  assign unused_err    = ^{err_inj_i, err_dir_i, err_bit_i};
  assign a_flip        = '0;
  assign b_flip        = '0;
  assign err_pending_o = 1'b0;
`endif

  // Each stage holds {valid, data}; data is kept zero whenever valid is clear.
  logic [PIPE_DATA_WIDTH:0] a_in;
  logic [PIPE_DATA_WIDTH:0] b_in;
  logic [PIPE_DATA_WIDTH:0] a2b_pipe [LATENCY];
  logic [PIPE_DATA_WIDTH:0] b2a_pipe [LATENCY];

  assign a_in = (is_active && a_txvalid_i) ? {1'b1, a_txdata_i ^ a_flip} : '0;
  assign b_in = (is_active && b_txvalid_i) ? {1'b1, b_txdata_i ^ b_flip} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || leaving) begin
      for (int i = 0; i < LATENCY; i++) begin
        a2b_pipe[i] <= '0;
        b2a_pipe[i] <= '0;
      end
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        a2b_pipe[i] <= a2b_pipe[i-1];
        b2a_pipe[i] <= b2a_pipe[i-1];
      end
      a2b_pipe[0] <= a_in;
      b2a_pipe[0] <= b_in;
    end
  end

  assign b_rxvalid_o = a2b_pipe[LATENCY-1][PIPE_DATA_WIDTH];
  assign b_rxdata_o  = a2b_pipe[LATENCY-1][PIPE_DATA_WIDTH-1:0];
  assign a_rxvalid_o = b2a_pipe[LATENCY-1][PIPE_DATA_WIDTH];
  assign a_rxdata_o  = b2a_pipe[LATENCY-1][PIPE_DATA_WIDTH-1:0];

  // Both sides may drop in one cycle, so the drop counter adds up to 2 and saturates.
  logic [1:0]           drop_inc;
  logic [CNT_WIDTH:0]   drop_sum;

  assign drop_inc = is_active ? 2'd0 : ({1'b0, a_txvalid_i} + {1'b0, b_txvalid_i});
  assign drop_sum = {1'b0, drop_cnt_o} + {{(CNT_WIDTH-1){1'b0}}, drop_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a2b_cnt_o  <= '0;
      b2a_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (b_rxvalid_o && (a2b_cnt_o != '1)) a2b_cnt_o <= a2b_cnt_o + CNT_WIDTH'(1);
      if (a_rxvalid_o && (b2a_cnt_o != '1)) b2a_cnt_o <= b2a_cnt_o + CNT_WIDTH'(1);
      drop_cnt_o <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_link_channel.sv
// Bench for pipe_link_channel: hand vectors and sequences plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_pipe_link_channel;
  localparam int W  = 256;
  localparam int L  = 4;
  localparam int D  = 16;
  localparam int CW = 32;
  localparam int BW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          link_en_i = 1'b0;
  logic [W-1:0]  a_txdata_i = '0;
  logic          a_txvalid_i = 1'b0;
  logic [W-1:0]  b_txdata_i = '0;
  logic          b_txvalid_i = 1'b0;
  logic          err_inj_i = 1'b0;
  logic          err_dir_i = 1'b0;
  logic [BW-1:0] err_bit_i = '0;
  logic [W-1:0]  a_rxdata_o, b_rxdata_o;
  logic          a_rxvalid_o, b_rxvalid_o, link_up_o, err_pending_o;
  logic [CW-1:0] a2b_cnt_o, b2a_cnt_o, drop_cnt_o;

  always #5 clk = ~clk;

  pipe_link_channel #(.PIPE_DATA_WIDTH(W), .LATENCY(L), .LINK_UP_DELAY(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .link_en_i(link_en_i),
    .a_txdata_i(a_txdata_i), .a_txvalid_i(a_txvalid_i), .a_rxdata_o(a_rxdata_o), .a_rxvalid_o(a_rxvalid_o),
    .b_txdata_i(b_txdata_i), .b_txvalid_i(b_txvalid_i), .b_rxdata_o(b_rxdata_o), .b_rxvalid_o(b_rxvalid_o),
    .link_up_o(link_up_o), .a2b_cnt_o(a2b_cnt_o), .b2a_cnt_o(b2a_cnt_o), .drop_cnt_o(drop_cnt_o),
    .err_inj_i(err_inj_i), .err_dir_i(err_dir_i), .err_bit_i(err_bit_i), .err_pending_o(err_pending_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: link is up once link_en has been high for D+1 consecutive edges;
  // beats accepted while up are scheduled for delivery L-1 edges after sampling.
  typedef struct { int due; logic [W-1:0] dat; } beat_t;
  beat_t         q_ab[$];
  beat_t         q_ba[$];
  int            edge_n, en_run;
  bit            m_up, m_pend, m_dir;
  logic [BW-1:0] m_bit;
  longint        m_ab, m_ba, m_drop;
  bit            e_bv, e_av;
  logic [W-1:0]  e_bd, e_ad;
  logic [W-1:0]  rx_b_log[$];
  logic [W-1:0]  rx_a_log[$];

  task automatic model_reset();
    q_ab.delete(); q_ba.delete();
    edge_n = 0; en_run = 0; m_up = 0; m_pend = 0; m_dir = 0; m_bit = '0;
    m_ab = 0; m_ba = 0; m_drop = 0;
    e_bv = 0; e_av = 0; e_bd = '0; e_ad = '0;
  endtask

  task automatic set_in(input bit en, input bit av, input logic [W-1:0] ad, input bit bv, input logic [W-1:0] bd);
    link_en_i = en; a_txvalid_i = av; a_txdata_i = ad; b_txvalid_i = bv; b_txdata_i = bd;
  endtask

  task automatic tick();
    logic [W-1:0] fa, fb;
    bit pb;
    @(posedge clk);
    edge_n++;
    if (e_bv) m_ab++;
    if (e_av) m_ba++;
    if (!m_up) m_drop += int'(a_txvalid_i) + int'(b_txvalid_i);
    fa = '0; fb = '0; pb = m_pend;
    if (m_up && !link_en_i) begin
      m_pend = 0;
    end else if (pb && m_up && ((!m_dir && a_txvalid_i) || (m_dir && b_txvalid_i))) begin
      if (!m_dir) fa[m_bit] = 1'b1; else fb[m_bit] = 1'b1;
      m_pend = 0;
    end else if (!pb && err_inj_i) begin
`ifdef PIPE_LINK_ERR_INJ_EN
      m_pend = 1; m_dir = err_dir_i; m_bit = err_bit_i;
`endif
    end
    if (m_up && !link_en_i) begin
      q_ab.delete(); q_ba.delete();
    end else if (m_up) begin
      if (a_txvalid_i) q_ab.push_back('{edge_n + L - 1, a_txdata_i ^ fa});
      if (b_txvalid_i) q_ba.push_back('{edge_n + L - 1, b_txdata_i ^ fb});
    end
    en_run = link_en_i ? ((en_run < 1000) ? en_run + 1 : en_run) : 0;
    m_up = (en_run >= D + 1);
    while (q_ab.size() > 0 && q_ab[0].due < edge_n) void'(q_ab.pop_front());
    while (q_ba.size() > 0 && q_ba[0].due < edge_n) void'(q_ba.pop_front());
    e_bv = (q_ab.size() > 0) && (q_ab[0].due == edge_n);
    e_bd = e_bv ? q_ab[0].dat : '0;
    e_av = (q_ba.size() > 0) && (q_ba[0].due == edge_n);
    e_ad = e_av ? q_ba[0].dat : '0;
    #1;
    chk("m_link_up", link_up_o, m_up);
    chk("m_b_rxvalid", b_rxvalid_o, e_bv);
    chk("m_b_rxdata", b_rxdata_o, e_bd);
    chk("m_a_rxvalid", a_rxvalid_o, e_av);
    chk("m_a_rxdata", a_rxdata_o, e_ad);
    chk("m_a2b_cnt", a2b_cnt_o, m_ab);
    chk("m_b2a_cnt", b2a_cnt_o, m_ba);
    chk("m_drop_cnt", drop_cnt_o, m_drop);
    chk("m_err_pending", err_pending_o, m_pend);
    if (b_rxvalid_o) rx_b_log.push_back(b_rxdata_o);
    if (a_rxvalid_o) rx_a_log.push_back(a_rxdata_o);
  endtask

  // Release reset with link_en high and expect link_up exactly at edge D+1.
  task automatic release_and_train();
    set_in(1, 0, '0, 0, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= D + 1; i++) begin
      tick();
      if (i == D) chk("bringup_edge16", link_up_o, 1'b0);
      if (i == D + 1) chk("bringup_edge17", link_up_o, 1'b1);
    end
  endtask

  typedef struct {
    bit en; bit av; logic [W-1:0] ad; bit bv; logic [W-1:0] bd;
    bit up; bit brv; logic [W-1:0] brd; bit arv; logic [W-1:0] ard;
  } vec_t;

  function automatic vec_t mk(input bit en, input bit av, input int ad, input bit bv, input int bd,
                              input bit up, input bit brv, input int brd, input bit arv, input int ard);
    vec_t v;
    v.en = en; v.av = av; v.ad = W'(ad); v.bv = bv; v.bd = W'(bd);
    v.up = up; v.brv = brv; v.brd = W'(brd); v.arv = arv; v.ard = W'(ard);
    return v;
  endfunction

  vec_t tbl[10];

  initial begin
    tbl[0] = mk(1, 1, 'h11, 0, 0,    1, 0, 0,    0, 0);
    tbl[1] = mk(1, 1, 'h22, 1, 'h33, 1, 0, 0,    0, 0);
    tbl[2] = mk(1, 0, 0,    1, 'h44, 1, 0, 0,    0, 0);
    tbl[3] = mk(1, 0, 0,    0, 0,    1, 1, 'h11, 0, 0);
    tbl[4] = mk(1, 1, 'h55, 0, 0,    1, 1, 'h22, 1, 'h33);
    tbl[5] = mk(1, 0, 0,    0, 0,    1, 0, 0,    1, 'h44);
    tbl[6] = mk(0, 1, 'h66, 0, 0,    0, 0, 0,    0, 0);
    tbl[7] = mk(0, 1, 'h77, 1, 'h88, 0, 0, 0,    0, 0);
    tbl[8] = mk(0, 0, 0,    1, 'h99, 0, 0, 0,    0, 0);
    tbl[9] = mk(0, 0, 0,    0, 0,    0, 0, 0,    0, 0);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_link_up", link_up_o, 1'b0);
    chk("reset_b_rxvalid", b_rxvalid_o, 1'b0);
    chk("reset_drop_cnt", drop_cnt_o, '0);

    // Bring-up
    release_and_train();

    // Single beat latency
    set_in(1, 1, W'('hA5), 0, '0);
    tick();
    set_in(1, 0, '0, 0, '0);
    tick();
    tick();
    chk("lat_early_vld", b_rxvalid_o, 1'b0);
    tick();
    chk("lat_vld", b_rxvalid_o, 1'b1);
    chk("lat_dat", b_rxdata_o, W'('hA5));
    tick();
    chk("lat_gone", b_rxvalid_o, 1'b0);
    chk("lat_a2b_cnt", a2b_cnt_o, 1);

    // Simultaneous back-to-back traffic
    rx_b_log.delete(); rx_a_log.delete();
    for (int i = 0; i < 8; i++) begin
      set_in(1, 1, W'('h100 + i), 1, W'('h200 + i));
      tick();
    end
    set_in(1, 0, '0, 0, '0);
    repeat (5) tick();
    chk("sim_b_count", rx_b_log.size(), 8);
    chk("sim_a_count", rx_a_log.size(), 8);
    for (int i = 0; i < 8 && i < rx_b_log.size() && i < rx_a_log.size(); i++) begin
      chk("sim_b_order", rx_b_log[i], W'('h100 + i));
      chk("sim_a_order", rx_a_log[i], W'('h200 + i));
    end
    chk("sim_a2b_cnt", a2b_cnt_o, 9);
    chk("sim_b2a_cnt", b2a_cnt_o, 8);
    chk("sim_drop_cnt", drop_cnt_o, 0);

    // Vector table: traffic in flight, then link drop and dropped beats
    for (int r = 0; r < 10; r++) begin
      set_in(tbl[r].en, tbl[r].av, tbl[r].ad, tbl[r].bv, tbl[r].bd);
      tick();
      chk($sformatf("tbl%0d_up", r), link_up_o, tbl[r].up);
      chk($sformatf("tbl%0d_brv", r), b_rxvalid_o, tbl[r].brv);
      chk($sformatf("tbl%0d_brd", r), b_rxdata_o, tbl[r].brd);
      chk($sformatf("tbl%0d_arv", r), a_rxvalid_o, tbl[r].arv);
      chk($sformatf("tbl%0d_ard", r), a_rxdata_o, tbl[r].ard);
    end
    chk("drop_after_link_down", drop_cnt_o, 3);

    // Randomized traffic with occasional link drops and error pulses
    link_en_i = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (link_en_i) link_en_i = ($urandom_range(0, 249) != 0);
      else           link_en_i = ($urandom_range(0, 7) == 0);
      a_txvalid_i = $urandom_range(0, 1);
      b_txvalid_i = $urandom_range(0, 1);
      a_txdata_i  = {8{$urandom}};
      b_txdata_i  = {8{$urandom}};
      err_inj_i   = ($urandom_range(0, 15) == 0);
      err_dir_i   = $urandom_range(0, 1);
      err_bit_i   = BW'($urandom_range(0, W - 1));
      tick();
    end
    err_inj_i = 1'b0;

    // Asynchronous reset asserted mid-stream
    set_in(1, 1, W'('hBEEF), 1, W'('hCAFE));
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_link_up", link_up_o, 1'b0);
    chk("arst_b_rxvalid", b_rxvalid_o, 1'b0);
    chk("arst_a_rxdata", a_rxdata_o, '0);
    chk("arst_a2b_cnt", a2b_cnt_o, '0);
    chk("arst_drop_cnt", drop_cnt_o, '0);
    chk("arst_err_pending", err_pending_o, 1'b0);
    repeat (2) @(posedge clk);
    release_and_train();

`ifdef PIPE_LINK_ERR_INJ_EN
    // Single-bit error on the first A->B beat after arming
    rx_b_log.delete();
    set_in(1, 0, '0, 0, '0);
    err_inj_i = 1'b1; err_dir_i = 1'b0; err_bit_i = BW'(5);
    tick();
    err_inj_i = 1'b0;
    chk("err_armed", err_pending_o, 1'b1);
    set_in(1, 1, '0, 0, '0);
    tick();
    chk("err_cleared", err_pending_o, 1'b0);
    tick();
    set_in(1, 0, '0, 0, '0);
    repeat (5) tick();
    chk("err_beats", rx_b_log.size(), 2);
    if (rx_b_log.size() == 2) begin
      chk("err_first", rx_b_log[0], W'('h20));
      chk("err_second", rx_b_log[1], W'('h00));
    end
`else
    // Error inputs have no effect in this build
    rx_b_log.delete();
    set_in(1, 0, '0, 0, '0);
    err_inj_i = 1'b1; err_dir_i = 1'b0; err_bit_i = BW'(5);
    tick();
    err_inj_i = 1'b0;
    chk("noerr_pending", err_pending_o, 1'b0);
    set_in(1, 1, '0, 0, '0);
    tick();
    set_in(1, 0, '0, 0, '0);
    repeat (5) tick();
    chk("noerr_beats", rx_b_log.size(), 1);
    if (rx_b_log.size() == 1) chk("noerr_data", rx_b_log[0], '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
